// File: rtl/med_blocos_stream.sv
// Streaming FATOR x FATOR block downscaler (rounded mean or top-left decimation).
// Keeps one accumulator row; valid/ready handshake on both sides; 1 pixel/clk at full rate.
module med_blocos_stream #(
    parameter int DATA_W     = 8,
    parameter int IMG_W      = 160,
    parameter int IMG_H      = 120,
    parameter int LOG2_FATOR = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              modo,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_done
);
    localparam int L     = LOG2_FATOR;
    localparam int FATOR = 1 << L;
    localparam int OUT_W = IMG_W / FATOR;
    localparam int ACC_W = DATA_W + 2 * L;
    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int BXW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int RND   = (1 << (2 * L)) >> 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_MASK = CW'(FATOR - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_MASK = RW'(FATOR - 1);

    logic [CW-1:0]     col_q, col_d, col_s;
    logic [RW-1:0]     row_q, row_d, row_s;
    logic              mode_q, mode_d, mode_s;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sof_q, out_sof_d;
    logic              out_eol_q, out_eol_d;
    logic              out_last_q, out_last_d;
    logic              frame_done_q, frame_done_d;

    logic [ACC_W-1:0]  acc_mem [OUT_W];
    logic [ACC_W-1:0]  acc_rd_s, acc_wdata_s;
    logic              acc_we_s;
    logic [BXW-1:0]    bx_s;
    logic              accept_s, first_s, emit_s;
    logic [ACC_W:0]    sum_s;
    logic [DATA_W-1:0] res_s;

    assign in_ready   = !out_valid_q || out_ready;
    assign accept_s   = in_valid && in_ready;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_sof    = out_sof_q;
    assign out_eol    = out_eol_q;
    assign frame_done = frame_done_q;

    // Effective pixel position, block role, accumulator update and block result
    always_comb begin
        col_s    = in_sof ? CW'(0) : col_q;
        row_s    = in_sof ? RW'(0) : row_q;
        bx_s     = BXW'(col_s >> L);
        first_s  = ((col_s & COL_MASK) == CW'(0)) && ((row_s & ROW_MASK) == RW'(0));
        emit_s   = ((col_s & COL_MASK) == COL_MASK) && ((row_s & ROW_MASK) == ROW_MASK);
        // A frame start (explicit or by counter wrap) picks up the new mode for its first pixel
        mode_s   = ((col_s == CW'(0)) && (row_s == RW'(0))) ? modo : mode_q;
        acc_rd_s = acc_mem[bx_s];
        acc_we_s = accept_s && (first_s || !mode_s);
        if (first_s) begin
            acc_wdata_s = ACC_W'(in_data);
        end else begin
            acc_wdata_s = acc_rd_s + ACC_W'(in_data);
        end
        sum_s = (ACC_W+1)'(acc_rd_s) + (ACC_W+1)'(in_data) + (ACC_W+1)'(RND);
        if (L == 0) begin
            res_s = in_data;
        end else if (mode_s) begin
            res_s = acc_rd_s[DATA_W-1:0];
        end else begin
            res_s = DATA_W'(sum_s >> (2 * L));
        end
    end

    // Next-state for counters, latched mode and the output register
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        mode_d       = mode_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_data_d   = out_data_q;
        out_sof_d    = out_sof_q;
        out_eol_d    = out_eol_q;
        out_last_d   = out_last_q;
        frame_done_d = out_valid_q && out_ready && out_last_q;
        if (accept_s) begin
            mode_d = mode_s;
            if (col_s == COL_LAST) begin
                col_d = CW'(0);
                row_d = (row_s == ROW_LAST) ? RW'(0) : row_s + RW'(1);
            end else begin
                col_d = col_s + CW'(1);
                row_d = row_s;
            end
            if (emit_s) begin
                out_valid_d = 1'b1;
                out_data_d  = res_s;
                out_sof_d   = (bx_s == BXW'(0)) && ((row_s >> L) == RW'(0));
                out_eol_d   = (bx_s == BXW'(OUT_W - 1));
                out_last_d  = (bx_s == BXW'(OUT_W - 1)) && (row_s == ROW_LAST);
            end else begin
                out_last_d = out_last_q;
            end
        end else begin
            mode_d = mode_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q        <= CW'(0);
            row_q        <= RW'(0);
            mode_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= DATA_W'(0);
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            mode_q       <= mode_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Accumulator row storage; contents need no reset
    always_ff @(posedge clk) begin
        if (acc_we_s) begin
            acc_mem[bx_s] <= acc_wdata_s;
        end
    end
endmodule
